// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/gnt/rvalid, redirect input and decode-side output.
// master = fetch unit, slave = memory/decode/branch environment.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        misalign;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst, inst_pc, opcode, funct3, funct7, misalign,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst, inst_pc, opcode, funct3, funct7, misalign,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem fetch, small instruction FIFO, redirect flush.
// FETCH_MISALIGN_CHECK_EN: misaligned redirect halts fetch and raises misalign; otherwise low bits are dropped.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic       clk,
    input logic       rst,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {REQ, WAIT, DROP, HALT} state_t;

    state_t                         state, state_n;
    logic [31:0]                    fetch_pc, fetch_pc_n, pend_pc;
    logic [FIFO_DEPTH-1:0][31:0]    fifo_inst, fifo_pc;
    logic [PW-1:0]                  rd_ptr, wr_ptr;
    logic [CW-1:0]                  count;
    logic                           fire, push, pop, busy, out_after;
    logic                           stale, stale_n, bad_tgt;
    logic [31:0]                    tgt, head_inst, head_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign tgt     = bus.redirect_pc;
    assign bad_tgt = bus.redirect_pc[1:0] != 2'b00;
`else
    assign tgt     = {bus.redirect_pc[31:2], 2'b00};
    assign bad_tgt = 1'b0;
`endif

    // Credit: never ask for more words than the FIFO can hold.
    assign bus.imem_req  = !rst && (state == REQ) && (count < DEPTH_C);
    assign bus.imem_addr = fetch_pc;
    assign fire          = bus.imem_req && bus.imem_gnt;
    assign bus.inst_valid = count != '0;
    assign pop           = bus.inst_valid && bus.inst_ready;
    assign push          = (state == WAIT) && bus.imem_rvalid && !bus.redirect_valid;
    // A response is still owed to us after this cycle.
    assign busy          = (state == WAIT) || (state == DROP) || stale;
    assign out_after     = fire || (busy && !bus.imem_rvalid);

    always_comb begin
        state_n    = state;
        stale_n    = stale;
        fetch_pc_n = fetch_pc;
        unique case (state)
            REQ:       if (fire) state_n = WAIT;
            WAIT, DROP: if (bus.imem_rvalid) state_n = REQ;
            HALT:      if (bus.imem_rvalid) stale_n = 1'b0;
        endcase
        if (fire) fetch_pc_n = fetch_pc + 32'd4;
        if (bus.redirect_valid) begin
            fetch_pc_n = tgt;
            if (bad_tgt) begin
                state_n = HALT;
                stale_n = out_after;
            end else begin
                state_n = out_after ? DROP : REQ;
                stale_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
            stale    <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            stale    <= stale_n;
            if (fire) pend_pc <= fetch_pc;
            if (bus.redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]   <= pend_pc;
        end
    end

    assign head_inst   = bus.inst_valid ? fifo_inst[rd_ptr] : '0;
    assign head_pc     = bus.inst_valid ? fifo_pc[rd_ptr]   : '0;
    assign bus.inst    = head_inst;
    assign bus.inst_pc = head_pc;
    assign bus.opcode  = head_inst[6:0];
    assign bus.funct3  = head_inst[14:12];
    assign bus.funct7  = head_inst[31:25];

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_q;
    always_ff @(posedge clk) begin
        if (rst)                     mis_q <= 1'b0;
        else if (bus.redirect_valid) mis_q <= bad_tgt;
    end
    assign bus.misalign = mis_q;
`else
    assign bus.misalign = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and delivered instructions are
// queued by the directed tests and checked by monitors as the DUT presents them.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if bus_w ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int total = 0;
    int bad   = 0;
    int n_fire = 0;
    int lat   = 1;
    int base  = 0;

    // Memory image: word 0 is addi x1,x0,10; other words encode their address in funct7/funct3.
    function automatic logic [31:0] inst_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return {a[8:2], 10'h0, a[4:2], 5'h1, 7'h33};
    endfunction

    function automatic exp_t exp_of(input logic [31:0] pc);
        exp_t e;
        e.inst = inst_at(pc);
        e.pc   = pc;
        if (pc == 32'h0) begin
            e.op = 7'h13; e.f3 = 3'h0; e.f7 = 7'h00;
        end else begin
            e.op = 7'h33; e.f3 = pc[4:2]; e.f7 = pc[8:2];
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Memory responder: grant recorded mid-cycle, rvalid driven 'lat' cycles later.
    logic        fire_q = 1'b0;
    logic [31:0] raddr  = '0;
    int          cd     = 0;
    always @(negedge clk) begin
        fire_q = !rst && bus.imem_req && bus.imem_gnt;
        if (fire_q) begin
            raddr = bus.imem_addr;
            n_fire++;
            if (addr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL req_addr: got fetch at %h want none", bus.imem_addr);
            end else chk("req_addr", bus.imem_addr, addr_q.pop_front());
        end
    end
    always @(posedge clk) begin
        #1;
        bus.imem_rvalid = 1'b0;
        if (rst) cd = 0;
        else begin
            if (fire_q) cd = lat;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = inst_at(raddr);
                end
            end
        end
    end

    logic fire_w = 1'b0;
    always @(negedge clk) fire_w = !rst && bus_w.imem_req && bus_w.imem_gnt;
    always @(posedge clk) begin
        #1;
        bus_w.imem_rvalid = fire_w && !rst;
        bus_w.imem_rdata  = 32'h0000_0013;
    end
    initial begin
        bus_w.imem_gnt = 1'b1; bus_w.inst_ready = 1'b1;
        bus_w.redirect_valid = 1'b0; bus_w.redirect_pc = '0;
    end

    // Decode-side monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL inst_unexpected: got pc %h want none", bus.inst_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("inst", bus.inst, e.inst);
                    chk("inst_pc", bus.inst_pc, e.pc);
                    chk("opcode", 32'(bus.opcode), 32'(e.op));
                    chk("funct3", 32'(bus.funct3), 32'(e.f3));
                    chk("funct7", 32'(bus.funct7), 32'(e.f7));
                end
            end else if (!bus.inst_valid) begin
                chk("idle_inst", bus.inst, 32'h0);
                chk("idle_pc", bus.inst_pc, 32'h0);
                chk("idle_fields", {15'b0, bus.funct7, bus.funct3, bus.opcode}, 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        exp_q.delete();
        addr_q.delete();
        repeat (2) step();
        @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_addr_w", bus_w.imem_addr, 32'hFFFF_FFF8);
        chk("rst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_misalign", 32'(bus.misalign), 32'h0);
        step();
        rst  = 1'b0;
        base = n_fire;
    endtask

    task automatic wait_n(input int target);
        for (int i = 0; i < 100 && n_fire < target; i++) step();
        chk("fire_count", n_fire, target);
    endtask

    task automatic finish_test();
        step();
        bus.imem_gnt   = 1'b0;
        bus.inst_ready = 1'b1;
        repeat (6) step();
        chk("exp_left", exp_q.size(), 0);
        chk("addr_left", addr_q.size(), 0);
    endtask

    logic [31:0] wtbl [3];

    initial begin
        bus.imem_gnt = 1'b0; bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;

        // Streaming fetch, ready always high.
        lat = 1; bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1;
        do_reset();
        addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
        exp_q.push_back(exp_of(32'h0)); exp_q.push_back(exp_of(32'h4)); exp_q.push_back(exp_of(32'h8));
        @(negedge clk); chk("req_first_cycle", 32'(bus.imem_req), 32'h1);
        step(); @(negedge clk); chk("valid_at_rvalid", 32'(bus.inst_valid), 32'h0);
        step(); @(negedge clk); chk("valid_after_rvalid", 32'(bus.inst_valid), 32'h1);
        wait_n(base + 3);
        finish_test();

        // Backpressure fills the FIFO and drops the request.
        lat = 1; bus.imem_gnt = 1'b1; bus.inst_ready = 1'b0;
        do_reset();
        addr_q.push_back(32'h0); addr_q.push_back(32'h4);
        exp_q.push_back(exp_of(32'h0)); exp_q.push_back(exp_of(32'h4));
        repeat (10) step();
        @(negedge clk);
        chk("full_req_low", 32'(bus.imem_req), 32'h0);
        chk("full_head_pc", bus.inst_pc, 32'h0);
        chk("full_fires", n_fire - base, 2);
        finish_test();

        // Redirect while waiting on a slow response: DROP then refetch.
        lat = 2; bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1;
        do_reset();
        addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8); addr_q.push_back(32'h100);
        exp_q.push_back(exp_of(32'h0)); exp_q.push_back(exp_of(32'h4)); exp_q.push_back(exp_of(32'h100));
        wait_n(base + 3);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("drop_req_low", 32'(bus.imem_req), 32'h0);
        chk("drop_valid", 32'(bus.inst_valid), 32'h0);
        wait_n(base + 4);
        finish_test();

        // Redirect coinciding with rvalid and a pop.
        lat = 1; bus.imem_gnt = 1'b1; bus.inst_ready = 1'b0;
        do_reset();
        addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h200);
        exp_q.push_back(exp_of(32'h0)); exp_q.push_back(exp_of(32'h200));
        wait_n(base + 2);
        bus.inst_ready = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("push_dropped", 32'(bus.inst_valid), 32'h0);
        chk("req_no_drop", 32'(bus.imem_req), 32'h1);
        chk("redirect_addr", bus.imem_addr, 32'h200);
        wait_n(base + 3);
        finish_test();

        // PC wrap on the high-reset instance.
        lat = 1; bus.imem_gnt = 1'b0; bus.inst_ready = 1'b1;
        wtbl[0] = 32'hFFFF_FFF8; wtbl[1] = 32'hFFFF_FFFC; wtbl[2] = 32'h0000_0000;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus_w.imem_req && bus_w.imem_gnt) break;
            end
            chk("wrap_fire", 32'(bus_w.imem_req && bus_w.imem_gnt), 32'h1);
            chk("wrap_addr", bus_w.imem_addr, wtbl[k]);
        end
        finish_test();

        // Misaligned redirect.
        lat = 1; bus.imem_gnt = 1'b0; bus.inst_ready = 1'b1;
        do_reset();
`ifdef FETCH_MISALIGN_CHECK_EN
        addr_q.push_back(32'h104);
        exp_q.push_back(exp_of(32'h104));
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h102;
        @(negedge clk); chk("misalign_same_cycle", 32'(bus.misalign), 32'h0);
        step();
        bus.redirect_valid = 1'b0; bus.imem_gnt = 1'b1;
        @(negedge clk);
        chk("misalign_set", 32'(bus.misalign), 32'h1);
        chk("halt_req_low", 32'(bus.imem_req), 32'h0);
        repeat (3) step();
        @(negedge clk);
        chk("halt_req_still_low", 32'(bus.imem_req), 32'h0);
        chk("halt_fires", n_fire - base, 0);
        step();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h104;
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("misalign_clear", 32'(bus.misalign), 32'h0);
        chk("resume_addr", bus.imem_addr, 32'h104);
`else
        addr_q.push_back(32'h100);
        exp_q.push_back(exp_of(32'h100));
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h102;
        step();
        bus.redirect_valid = 1'b0; bus.imem_gnt = 1'b1;
        @(negedge clk);
        chk("misalign_tied", 32'(bus.misalign), 32'h0);
        chk("aligned_addr", bus.imem_addr, 32'h100);
`endif
        wait_n(base + 1);
        finish_test();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
